// File: rtl/matrix_scan_sequencer_pkg.sv
// Shared definitions for the LED matrix scan sequencer: state encoding,
// default geometry and a couple of constant helpers for sizing.
package matrix_scan_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    localparam int LED_ROWS_DEFAULT = 4;
    localparam int ROW_W            = 4;
    localparam int TIMER_W_DEFAULT  = 13;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer holds N-1 for an N-clock dwell; one spare bit keeps N=1 legal.
    function automatic int timer_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/matrix_scan_sequencer_scan_timer.sv
// Loadable down-counter shared by all timed states; tc flags the last clock
// of a dwell that was started by loading N-1.
module scan_timer
    import matrix_scan_sequencer_pkg::*;
#(
    parameter int W = TIMER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/matrix_scan_sequencer.sv
// Row-scan sequencer for a multiplexed LED matrix: shift, blank, latch and
// display each row in turn, with frame-boundary buffer swap and shift timeout.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | dark, row 0, waiting for enable
// SHIFT       | one-clock shift_start pulse for cur_row
// WAIT_SHIFT  | waiting for shift_done, bounded by SHIFT_TIMEOUT
// BLANK       | dark settle time before the latch
// LATCH       | le high, row_addr switched to cur_row
// DISPLAY     | gclk running, outputs lit for ON_CYCLES
module matrix_scan_sequencer
    import matrix_scan_sequencer_pkg::*;
#(
    parameter int LED_ROWS      = LED_ROWS_DEFAULT,
    parameter int BLANK_CYCLES  = 8,
    parameter int LE_CYCLES     = 2,
    parameter int ON_CYCLES     = 1024,
    parameter int SHIFT_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             shift_start,
    output logic [ROW_W-1:0] shift_row,
    input  logic             shift_done,
    output logic             le,
    output logic             blank,
    output logic             gclk_en,
    output logic [ROW_W-1:0] row_addr,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             buf_sel,
    output logic             frame_tick,
    output logic             err
);

    localparam int CW = timer_width(max_of(max_of(SHIFT_TIMEOUT, ON_CYCLES),
                                           max_of(BLANK_CYCLES, LE_CYCLES)));

    localparam logic [CW-1:0]    T_WAIT   = CW'(SHIFT_TIMEOUT - 1);
    localparam logic [CW-1:0]    T_BLANK  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]    T_LE     = CW'(LE_CYCLES - 1);
    localparam logic [CW-1:0]    T_ON     = CW'(ON_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LED_ROWS - 1);

    scan_state_t      state;
    logic [ROW_W-1:0] cur_row;
    logic [ROW_W-1:0] row_next;
    logic             row_wrap;
    logic             tmr_load;
    logic [CW-1:0]    tmr_value;
    logic             tmr_tc;

    scan_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .tc    (tmr_tc)
    );

    assign row_wrap = (cur_row == LAST_ROW);
    assign row_next = row_wrap ? '0 : cur_row + 1'b1;

    // The timer is loaded on the clock that enters each timed state so the
    // dwell starts counting on the entry clock itself.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_SHIFT: begin
                tmr_load  = 1'b1;
                tmr_value = T_WAIT;
            end
            ST_WAIT_SHIFT: begin
                if (shift_done || tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_value = T_BLANK;
                end
            end
            ST_BLANK: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_value = T_LE;
                end
            end
            ST_LATCH: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_value = T_ON;
                end
            end
            default: begin
                tmr_load  = 1'b0;
                tmr_value = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cur_row     <= '0;
            shift_start <= 1'b0;
            shift_row   <= '0;
            le          <= 1'b0;
            blank       <= 1'b1;
            gclk_en     <= 1'b0;
            row_addr    <= '0;
            swap_ack    <= 1'b0;
            buf_sel     <= 1'b0;
            frame_tick  <= 1'b0;
            err         <= 1'b0;
        end else begin
            shift_start <= 1'b0;
            swap_ack    <= 1'b0;
            frame_tick  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cur_row <= '0;
                    blank   <= 1'b1;
                    gclk_en <= 1'b0;
                    le      <= 1'b0;
                    if (enable) begin
                        state       <= ST_SHIFT;
                        shift_start <= 1'b1;
                        shift_row   <= '0;
                    end
                end
                ST_SHIFT: begin
                    state <= ST_WAIT_SHIFT;
                end
                ST_WAIT_SHIFT: begin
                    if (shift_done) begin
                        state <= ST_BLANK;
                    end else if (tmr_tc) begin
                        err   <= 1'b1;
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (tmr_tc) begin
                        state    <= ST_LATCH;
                        le       <= 1'b1;
                        row_addr <= cur_row;
                    end
                end
                ST_LATCH: begin
                    if (tmr_tc) begin
                        state   <= ST_DISPLAY;
                        le      <= 1'b0;
                        blank   <= 1'b0;
                        gclk_en <= 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (tmr_tc) begin
                        blank   <= 1'b1;
                        gclk_en <= 1'b0;
                        // Only a completed frame ticks and may swap buffers.
                        if (row_wrap) begin
                            frame_tick <= 1'b1;
                            if (swap_req) begin
                                buf_sel  <= ~buf_sel;
                                swap_ack <= 1'b1;
                            end
                        end
                        if (enable) begin
                            cur_row     <= row_next;
                            state       <= ST_SHIFT;
                            shift_start <= 1'b1;
                            shift_row   <= row_next;
                        end else begin
                            cur_row <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Bench for matrix_scan_sequencer: table of row scenarios, randomized rows
// against a segment-timeline model, and an asynchronous reset during LATCH.
module tb_matrix_scan_sequencer;

    localparam int ROWS = 4;
    localparam int BL   = 3;
    localparam int LEC  = 2;
    localparam int ON   = 16;
    localparam int TO   = 32;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       shift_start;
    logic [3:0] shift_row;
    logic       shift_done;
    logic       le;
    logic       blank;
    logic       gclk_en;
    logic [3:0] row_addr;
    logic       swap_req;
    logic       swap_ack;
    logic       buf_sel;
    logic       frame_tick;
    logic       err;

    matrix_scan_sequencer #(
        .LED_ROWS(ROWS), .BLANK_CYCLES(BL), .LE_CYCLES(LEC),
        .ON_CYCLES(ON), .SHIFT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .shift_start(shift_start), .shift_row(shift_row), .shift_done(shift_done),
        .le(le), .blank(blank), .gclk_en(gclk_en), .row_addr(row_addr),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
        .frame_tick(frame_tick), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycno = 0;

    // Model of the observable state that persists across cycles.
    logic [3:0] m_row  = 4'd0;
    logic [3:0] m_addr = 4'd0;
    logic       m_buf  = 1'b0;
    logic       m_err  = 1'b0;
    logic       m_ack  = 1'b0;
    logic       m_tick = 1'b0;

    typedef struct {
        int         delay;
        logic       swp;
        logic       en_end;
        int         spur_b;
        int         spur_d;
        logic [3:0] exp_row;
        logic       exp_err;
        logic       exp_buf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input logic ss, input logic le_e, input logic bl_e,
                       input logic gc_e, input string nm);
        logic [15:0] a, e;
        a = {shift_start, (shift_start ? shift_row : 4'd0), le, blank, gclk_en,
             row_addr, swap_ack, buf_sel, frame_tick, err};
        e = {ss, (ss ? m_row : 4'd0), le_e, bl_e, gc_e,
             m_addr, m_ack, m_buf, m_tick, m_err};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h (ss,row,le,blank,gclk,addr,ack,buf,tick,err)",
                     nm, cycno, a, e);
        end
    endtask

    task automatic cyc(input logic ss, input logic le_e, input logic bl_e,
                       input logic gc_e, input logic dn, input string nm);
        chk(ss, le_e, bl_e, gc_e, nm);
        m_ack  = 1'b0;
        m_tick = 1'b0;
        shift_done = dn;
        @(negedge clk);
        cycno++;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle");
    endtask

    task automatic start_scan();
        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle_go");
    endtask

    // One row as a timeline of segments: SHIFT, WAIT (shifter delay or
    // timeout), BLANK, LATCH, DISPLAY. shift_done is driven at cycle d after
    // shift_start, wherever that lands; spurious pulses go into BLANK/DISPLAY.
    task automatic do_row(input int d, input logic swp, input logic en_end,
                          input int sb, input int sd, input bit abort);
        int w;
        int t;
        w = (d <= TO) ? d : TO;
        swap_req = swp;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "shift");
        t = 1;
        for (int i = 0; i < w; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, (t == d), "wait");
            t++;
        end
        if (d > TO) m_err = 1'b1;
        for (int i = 0; i < BL; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, (t == d) || (i == sb), "blank");
            t++;
        end
        m_addr = m_row;
        for (int i = 0; i < LEC; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, (t == d), "latch");
            t++;
            if (abort) return;
        end
        for (int i = 0; i < ON; i++) begin
            if (i == 8) enable = en_end;
            cyc(1'b0, 1'b0, 1'b0, 1'b1, (t == d) || (i == sd), "display");
            t++;
        end
        if (m_row == 4'(ROWS - 1)) begin
            m_tick = 1'b1;
            if (swp) begin
                m_buf = ~m_buf;
                m_ack = 1'b1;
            end
            m_row = 4'd0;
        end else begin
            m_row = m_row + 4'd1;
        end
        if (!en_end) m_row = 4'd0;
    endtask

    initial begin
        bit running;
        logic [1:0] ob;

        rst        = 1'b1;
        enable     = 1'b0;
        shift_done = 1'b0;
        swap_req   = 1'b0;
        running    = 1'b0;

        //            delay swp  en  sb  sd  row err buf
        tbl[0]  = '{ 5, 1'b0, 1'b1, -1, -1, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{ 5, 1'b1, 1'b1,  1,  7, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{ 5, 1'b1, 1'b1,  0, 15, 4'd2, 1'b0, 1'b0};
        tbl[3]  = '{ 5, 1'b1, 1'b1,  2,  0, 4'd3, 1'b0, 1'b1};
        tbl[4]  = '{ 5, 1'b0, 1'b1, -1, -1, 4'd0, 1'b0, 1'b1};
        tbl[5]  = '{ 1, 1'b0, 1'b1, -1, -1, 4'd1, 1'b0, 1'b1};
        tbl[6]  = '{12, 1'b1, 1'b0, -1, -1, 4'd2, 1'b0, 1'b1};
        tbl[7]  = '{ 5, 1'b0, 1'b1, -1, -1, 4'd0, 1'b0, 1'b1};
        tbl[8]  = '{32, 1'b0, 1'b1, -1, -1, 4'd1, 1'b0, 1'b1};
        tbl[9]  = '{40, 1'b0, 1'b1, -1, -1, 4'd2, 1'b1, 1'b1};
        tbl[10] = '{ 3, 1'b0, 1'b1, -1, -1, 4'd3, 1'b1, 1'b1};

        #2 rst = 1'b0;
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        rst = 1'b1;

        for (int k = 0; k < 11; k++) begin
            if (!running) begin
                idle(3);
                start_scan();
            end
            total++;
            if ({shift_start, shift_row} !== {1'b1, tbl[k].exp_row}) begin
                bad++;
                $display("FAIL tbl_row[%0d] got=%b/%0d want=1/%0d", k, shift_start, shift_row, tbl[k].exp_row);
            end
            do_row(tbl[k].delay, tbl[k].swp, tbl[k].en_end, tbl[k].spur_b, tbl[k].spur_d, 1'b0);
            ob = {err, buf_sel};
            total++;
            if (ob !== {tbl[k].exp_err, tbl[k].exp_buf}) begin
                bad++;
                $display("FAIL tbl_flags[%0d] got err,buf=%b want=%b", k, ob, {tbl[k].exp_err, tbl[k].exp_buf});
            end
            running = tbl[k].en_end;
        end

        for (int k = 0; k < 40; k++) begin
            logic en_end;
            if (!running) begin
                idle($urandom_range(1, 4));
                start_scan();
            end
            en_end = ($urandom_range(0, 7) != 0);
            do_row($urandom_range(1, 36), ($urandom_range(0, 3) == 0), en_end,
                   $urandom_range(0, 3), $urandom_range(0, 20), 1'b0);
            running = en_end;
        end

        // Reset in the middle of a latch pulse.
        if (!running) begin
            idle(2);
            start_scan();
        end
        do_row(5, 1'b0, 1'b1, -1, -1, 1'b1);
        #2 rst = 1'b0;
        m_row = 4'd0; m_addr = 4'd0; m_buf = 1'b0; m_err = 1'b0;
        m_ack = 1'b0; m_tick = 1'b0;
        enable = 1'b0;
        #1 chk(1'b0, 1'b0, 1'b1, 1'b0, "rst_async");
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_hold");
        rst = 1'b1;
        idle(2);
        start_scan();
        do_row(5, 1'b0, 1'b1, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_scan_sequencer.md
MATRIX_SCAN_SEQUENCER -- requirements
Module: matrix_scan_sequencer

Interface
REQ-001 Parameter LED_ROWS, default 4: scanned rows per frame, 2..16.
REQ-002 Parameter BLANK_CYCLES, default 8: blanking clocks before each latch, at least 1.
REQ-003 Parameter LE_CYCLES, default 2: latch pulse width in clocks, at least 1.
REQ-004 Parameter ON_CYCLES, default 1024: display clocks per row, at least 1.
REQ-005 Parameter SHIFT_TIMEOUT, default 4096: maximum clocks to wait for shift_done.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  scan run request.
REQ-009 shift_start  output  1  one-cycle pulse requesting the shifter to load row shift_row.
REQ-010 shift_row  output  4  row index for the shifter; valid while shift_start=1.
REQ-011 shift_done  input  1  one-cycle pulse from the shifter marking its completion.
REQ-012 le  output  1  driver latch enable.
REQ-013 blank  output  1  1 means outputs are dark.
REQ-014 gclk_en  output  1  gates GCLK generation.
REQ-015 row_addr  output  4  row select driving {D,C,B,A}.
REQ-016 swap_req  input  1  level request to swap frame buffers.
REQ-017 swap_ack  output  1  one-cycle pulse confirming the swap.
REQ-018 buf_sel  output  1  frame buffer currently being displayed.
REQ-019 frame_tick  output  1  one-cycle pulse at the end of each frame.
REQ-020 err  output  1  sticky shift-timeout flag.

Function
REQ-021 The FSM SHALL have the states IDLE, SHIFT, WAIT_SHIFT, BLANK, LATCH and DISPLAY; every output SHALL be registered.
REQ-022 IDLE: blank=1, gclk_en=0, cur_row=0; the FSM SHALL go to SHIFT on the first clock with enable=1.
REQ-023 SHIFT: the FSM SHALL hold one cycle with shift_start=1 and shift_row=cur_row, then go to WAIT_SHIFT.
REQ-024 shift_done SHALL be accepted only in WAIT_SHIFT and ignored in every other state; accepting it SHALL move the FSM to BLANK.
REQ-025 WAIT_SHIFT SHALL count clocks; when SHIFT_TIMEOUT is reached the FSM SHALL set err=1 and go to BLANK anyway.
REQ-026 BLANK: blank=1, gclk_en=0, le=0 for exactly BLANK_CYCLES clocks, then go to LATCH.
REQ-027 LATCH: le=1 for exactly LE_CYCLES clocks, with row_addr loaded to cur_row on the entry clock; blank SHALL stay 1.
REQ-028 DISPLAY: blank=0, gclk_en=1 for exactly ON_CYCLES clocks.
REQ-029 At the end of DISPLAY, cur_row SHALL increment, wrapping from LED_ROWS-1 to 0.
REQ-030 On that wrap: frame_tick SHALL pulse one cycle; if swap_req=1, buf_sel SHALL toggle and swap_ack SHALL pulse in the same cycle.
REQ-031 A swap SHALL occur only at a frame boundary, and at most once per frame.
REQ-032 enable SHALL be sampled only in IDLE and on the last DISPLAY clock; enable=0 at that point SHALL go to IDLE, with blank=1 on the next clock.
REQ-033 A mid-frame return to IDLE SHALL restart the scan at row 0 without emitting frame_tick.
REQ-034 err SHALL clear only on reset.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE with: shift_start=0, shift_row=0, le=0, blank=1, gclk_en=0, row_addr=0, swap_ack=0, buf_sel=0, frame_tick=0, err=0, and all counters 0.
REQ-036 Reset asserted mid-operation SHALL abandon any pending shift handshake; blank SHALL be 1 from the reset edge onward.

Structure
REQ-037 A shared package SHALL hold: the state encoding, the LED_ROWS default, and the row_addr width constant.
REQ-038 A single down-counter sub-module, scan_timer, SHALL be used for BLANK, LATCH, DISPLAY and the timeout; no other sub-modules.

Verification
REQ-039 Params LED_ROWS=4, BLANK_CYCLES=3, LE_CYCLES=2, ON_CYCLES=16, shifter done 5 clocks after start -> row_addr sequence 0,1,2,3,0; each le pulse 2 clocks wide, preceded by 3 blank clocks; gclk_en high 16 clocks per row.
REQ-040 swap_req held high from row 1 -> exactly one swap_ack, buf_sel 0->1, coincident with frame_tick after row 3; no toggle mid-frame.
REQ-041 shift_done withheld, SHIFT_TIMEOUT=32 -> err=1 after 32 clocks in WAIT_SHIFT; the sequence continues to BLANK.
REQ-042 Spurious shift_done pulses during DISPLAY and BLANK -> no state change.
REQ-043 enable dropped during row 2 DISPLAY -> DISPLAY completes; IDLE with blank=1; re-enable restarts at row 0 with no frame_tick.
REQ-044 rst pulsed low during LATCH -> le=0 and blank=1 immediately; every output at its reset value.
